// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : addsub_pkg
//  Description: Shared constants for the bit-serial adder/subtractor:
//               controller state encoding and operation-mode codes.
//  Revision   : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    // Controller states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Operation select
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/fa_cell.sv
`default_nettype none
// ============================================================================
//  Module     : fa_cell
//  Description: Combinational 1-bit full adder.
//  Ports      : a, b, cin  - addend bits and carry in
//               sum, cout  - sum bit and carry out
//  Revision   : 1.0 - initial release
// ============================================================================
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign sum      = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);

endmodule : fa_cell
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module     : serial_addsub
//  Description: Bit-serial adder/subtractor. Operands are captured on a start
//               request in IDLE and processed LSB first, one bit per clock,
//               through a single full-adder cell. A one-cycle done pulse marks
//               result, carry/borrow and signed-overflow flags as valid.
//  Ports      : clk       - clock, rising edge
//               reset     - asynchronous active-high reset
//               start     - request, honoured only in IDLE
//               mode      - 0 = a+b, 1 = a-b, sampled with start
//               a, b      - WIDTH-bit operands, sampled with start
//               busy      - high while bits are being processed
//               done      - one-cycle completion pulse
//               result    - sum/difference, held until next accepted start
//               carry_out - add: carry out; sub: 1 = no borrow
//               overflow  - signed overflow
//  Revision   : 1.0 - initial release
// ============================================================================
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int              CNTW     = $clog2(WIDTH);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CNTW-1:0]  cnt;
    logic             carry;
    logic             c_msb;
    logic             fa_sum;
    logic             fa_cout;

    fa_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign busy = (state == SHIFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            c_msb     <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b and seed carry-in with 1.
                        a_sr   <= a;
                        b_sr   <= (mode == MODE_SUB) ? ~b : b;
                        carry  <= mode;
                        cnt    <= '0;
                        result <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    result <= {fa_sum, result[WIDTH-1:1]};
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    carry  <= fa_cout;
                    if (cnt == CNT_LAST) begin
                        // Carry into the MSB is needed for the signed-overflow flag.
                        c_msb <= carry;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                DONE: begin
                    done      <= 1'b1;
                    carry_out <= carry;
                    overflow  <= c_msb ^ carry;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_addsub
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module     : tb_serial_addsub
//  Description: Directed self-checking bench for serial_addsub (WIDTH=8).
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    int tests_run;
    int tests_failed;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one operation from IDLE (caller sits #1 after a rising edge)
    // and returns what the DUT reported. lat counts edges after the sampling
    // edge until done is seen; bcnt counts samples with busy high.
    task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic om,
                          output int lat, output int bcnt, output logic [7:0] r,
                          output logic c, output logic o);
        a     = oa;
        b     = ob;
        mode  = om;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'hFF;
        b     = 8'hFF;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        r = result;
        c = carry_out;
        o = overflow;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, result, carry_out, overflow} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%0d c=%b o=%b, want all 0",
                     busy, done, result, carry_out, overflow);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_add;
        logic [7:0] ta[3], tbv[3], er[3];
        logic       ec[3], eo[3];
        int lat, bcnt;
        logic [7:0] r;
        logic c, o;
        ta = '{8'd100, 8'd200, 8'd127};
        tbv = '{8'd27, 8'd100, 8'd1};
        er = '{8'd127, 8'd44, 8'd128};
        ec = '{1'b0, 1'b1, 1'b0};
        eo = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tbv[i], 1'b0, lat, bcnt, r, c, o);
            tests_run++;
            if (lat !== 9) begin
                tests_failed++;
                $display("FAIL add%0d_latency: got %0d edges after start, want 9", i, lat);
            end
            tests_run++;
            if (bcnt !== 8) begin
                tests_failed++;
                $display("FAIL add%0d_busy: busy high %0d cycles, want 8", i, bcnt);
            end
            tests_run++;
            if (r !== er[i] || c !== ec[i] || o !== eo[i]) begin
                tests_failed++;
                $display("FAIL add%0d_result: got r=%0d c=%b o=%b, want r=%0d c=%b o=%b",
                         i, r, c, o, er[i], ec[i], eo[i]);
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (done !== 1'b0 || result !== er[i]) begin
                tests_failed++;
                $display("FAIL add%0d_hold: got done=%b result=%0d, want done=0 result=%0d",
                         i, done, result, er[i]);
            end
        end
    endtask

    task automatic test_sub;
        int lat, bcnt;
        logic [7:0] r;
        logic c, o;
        run_op(8'd50, 8'd20, 1'b1, lat, bcnt, r, c, o);
        tests_run++;
        if (lat !== 9 || r !== 8'd30 || c !== 1'b1 || o !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_50_20: got lat=%0d r=%0d c=%b o=%b, want lat=9 r=30 c=1 o=0",
                     lat, r, c, o);
        end
        @(posedge clk);
        #1;
        run_op(8'd20, 8'd50, 1'b1, lat, bcnt, r, c, o);
        tests_run++;
        if (lat !== 9 || r !== 8'd226 || c !== 1'b0 || o !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_20_50: got lat=%0d r=%0d c=%b o=%b, want lat=9 r=226 c=0 o=0",
                     lat, r, c, o);
        end
    endtask

    // Second start issued in the very cycle done is high.
    task automatic test_back_to_back;
        int lat, bcnt;
        logic [7:0] r;
        logic c, o;
        @(posedge clk);
        #1;
        run_op(8'd1, 8'd2, 1'b0, lat, bcnt, r, c, o);
        run_op(8'd128, 8'd128, 1'b0, lat, bcnt, r, c, o);
        tests_run++;
        if (lat !== 9 || r !== 8'd0 || c !== 1'b1 || o !== 1'b1) begin
            tests_failed++;
            $display("FAIL back_to_back: got lat=%0d r=%0d c=%b o=%b, want lat=9 r=0 c=1 o=1",
                     lat, r, c, o);
        end
    endtask

    task automatic test_ignored_start;
        int pulses;
        logic [7:0] r;
        @(posedge clk);
        #1;
        a     = 8'd100;
        b     = 8'd27;
        mode  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a     = 8'd1;
        b     = 8'd1;
        mode  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        r      = 8'hXX;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                r = result;
            end
        end
        tests_run++;
        if (pulses !== 1) begin
            tests_failed++;
            $display("FAIL ignored_start_pulses: got %0d done pulses, want 1", pulses);
        end
        tests_run++;
        if (r !== 8'd127) begin
            tests_failed++;
            $display("FAIL ignored_start_result: got %0d, want 127", r);
        end
    endtask

    task automatic test_reset_abort;
        int lat, bcnt, pulses;
        logic [7:0] r;
        logic c, o;
        a     = 8'd100;
        b     = 8'd27;
        mode  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_abort: got busy=%b done=%b result=%0d, want 0 0 0",
                     busy, done, result);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        tests_run++;
        if (pulses !== 0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got pulses=%0d c=%b o=%b, want 0 0 0",
                     pulses, carry_out, overflow);
        end
        run_op(8'd20, 8'd50, 1'b1, lat, bcnt, r, c, o);
        tests_run++;
        if (lat !== 9 || r !== 8'd226 || c !== 1'b0 || o !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_reset_op: got lat=%0d r=%0d c=%b o=%b, want lat=9 r=226 c=0 o=0",
                     lat, r, c, o);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_ignored_start();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_serial_addsub
`default_nettype wire
